// File: rtl/vera_seq_pkg.sv
// Shared definitions for the VERA init sequencer: opcodes, FSM states and
// command-word field accessors.
package vera_seq_pkg;

    localparam logic [2:0] OP_WRITE    = 3'd0;
    localparam logic [2:0] OP_DELAY    = 3'd1;
    localparam logic [2:0] OP_WAIT_VB  = 3'd2;
    localparam logic [2:0] OP_WAIT_IRQ = 3'd3;
    localparam logic [2:0] OP_END      = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DELAY,
        ST_WAIT_VB,
        ST_WAIT_IRQ,
        ST_DONE
    } state_e;

    // Command word layout: [15:13] op, [12:8] register address, [7:0] data.
    function automatic logic [2:0] cmdOp(input logic [15:0] word);
        return word[15:13];
    endfunction

    function automatic logic [4:0] cmdAddr(input logic [15:0] word);
        return word[12:8];
    endfunction

    function automatic logic [7:0] cmdData(input logic [15:0] word);
        return word[7:0];
    endfunction

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vera_seq_timer.sv
// Loadable down-counter with a zero flag; shared by the bus strobe phases
// and the DELAY command.
module vera_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // A state lasting N cycles loads N-1 on entry and leaves when zero is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/vera_init_sequencer.sv
// Scripted VERA external-bus master driven by a synchronous command ROM.
// Optional feature: define VERA_SEQ_IRQ_WAIT_EN to make op 3 wait for irq_n low.
module vera_init_sequencer
    import vera_seq_pkg::*;
#(
    parameter int ROM_AW     = 8,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int DELAY_UNIT = 256,
    parameter int AUTO_START = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    input  logic              vblank_i,
    input  logic              irq_n_i,
    output logic              bus_cs_n_o,
    output logic              bus_rd_n_o,
    output logic              bus_wr_n_o,
    output logic [4:0]        bus_a_o,
    output logic [7:0]        bus_d_out_o,
    output logic              bus_d_oe_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int TMR_MAX = maxOf(maxOf(255 * DELAY_UNIT, SETUP_CYC),
                                   maxOf(STROBE_CYC, HOLD_CYC));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]  SETUP_LD  = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0]  STROBE_LD = TMR_W'(STROBE_CYC - 1);
    localparam logic [TMR_W-1:0]  HOLD_LD   = TMR_W'(HOLD_CYC - 1);
    localparam logic [ROM_AW-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] romAddr_q, romAddr_d;
    logic [4:0]        busA_q, busA_d;
    logic [7:0]        busD_q, busD_d;
    logic              autoPend_q, autoPend_d;
    logic              csN_q, wrN_q, dOe_q, busy_q, done_q;
    logic              vblankPrev_q;

    logic              tmrLoad;
    logic [TMR_W-1:0]  tmrVal;
    logic              tmrZero;
    logic [TMR_W-1:0]  delayLd;
    logic              advance;

    assign delayLd = TMR_W'(cmdData(rom_data_i)) * TMR_W'(DELAY_UNIT) - TMR_W'(1);

    vera_seq_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (tmrLoad),
        .load_val_i(tmrVal),
        .zero_o    (tmrZero)
    );

    // Next-state logic; 'advance' retires the current command and either
    // fetches the next word or stops at the last ROM address (no wrap).
    always_comb begin
        state_d    = state_q;
        romAddr_d  = romAddr_q;
        busA_d     = busA_q;
        busD_d     = busD_q;
        autoPend_d = autoPend_q;
        tmrLoad    = 1'b0;
        tmrVal     = '0;
        advance    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i || autoPend_q) begin
                    state_d    = ST_FETCH;
                    romAddr_d  = '0;
                    autoPend_d = 1'b0;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (cmdOp(rom_data_i))
                    OP_WRITE: begin
                        state_d = ST_SETUP;
                        busA_d  = cmdAddr(rom_data_i);
                        busD_d  = cmdData(rom_data_i);
                        tmrLoad = 1'b1;
                        tmrVal  = SETUP_LD;
                    end
                    OP_DELAY: begin
                        if (cmdData(rom_data_i) == 8'd0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = ST_DELAY;
                            tmrLoad = 1'b1;
                            tmrVal  = delayLd;
                        end
                    end
                    OP_WAIT_VB: state_d = ST_WAIT_VB;
`ifdef VERA_SEQ_IRQ_WAIT_EN
                    OP_WAIT_IRQ: state_d = ST_WAIT_IRQ;
`endif
                    OP_END: state_d = ST_DONE;
                    default: advance = 1'b1;
                endcase
            end
            ST_SETUP: begin
                if (tmrZero) begin
                    state_d = ST_STROBE;
                    tmrLoad = 1'b1;
                    tmrVal  = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (tmrZero) begin
                    state_d = ST_HOLD;
                    tmrLoad = 1'b1;
                    tmrVal  = HOLD_LD;
                end
            end
            ST_HOLD: advance = tmrZero;
            ST_DELAY: advance = tmrZero;
            ST_WAIT_VB: advance = vblank_i && !vblankPrev_q;
            ST_WAIT_IRQ: begin
`ifdef VERA_SEQ_IRQ_WAIT_EN
                advance = !irq_n_i;
`else
                advance = 1'b1;
`endif
            end
            ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_FETCH;
                    romAddr_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (romAddr_q == LAST_ADDR) begin
                state_d = ST_DONE;
            end else begin
                state_d   = ST_FETCH;
                romAddr_d = romAddr_q + ROM_AW'(1);
            end
        end
    end

`ifndef VERA_SEQ_IRQ_WAIT_EN
    logic unusedIrq;
    assign unusedIrq = irq_n_i;
`endif

    // Bus strobes and status are registered from the next state so they
    // change cleanly on the clock edge that enters each phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            romAddr_q    <= '0;
            busA_q       <= '0;
            busD_q       <= '0;
            autoPend_q   <= (AUTO_START != 0);
            csN_q        <= 1'b1;
            wrN_q        <= 1'b1;
            dOe_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vblankPrev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            romAddr_q    <= romAddr_d;
            busA_q       <= busA_d;
            busD_q       <= busD_d;
            autoPend_q   <= autoPend_d;
            csN_q        <= !(state_d inside {ST_SETUP, ST_STROBE});
            wrN_q        <= (state_d != ST_STROBE);
            dOe_q        <= (state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
            busy_q       <= !(state_d inside {ST_IDLE, ST_DONE});
            done_q       <= (state_d == ST_DONE);
            vblankPrev_q <= vblank_i;
        end
    end

    assign rom_addr_o  = romAddr_q;
    assign bus_cs_n_o  = csN_q;
    assign bus_rd_n_o  = 1'b1;
    assign bus_wr_n_o  = wrN_q;
    assign bus_a_o     = busA_q;
    assign bus_d_out_o = busD_q;
    assign bus_d_oe_o  = dOe_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_vera_init_sequencer.sv
// Scoreboard bench for vera_init_sequencer: stimulus queues expected bus
// writes, a monitor checks every completed write strobe against them.
module tb_vera_init_sequencer;

    localparam int ROM_AW     = 3;
    localparam int ROM_DEPTH  = 1 << ROM_AW;
    localparam int W_CS_LOW   = 0;
    localparam int W_CS_HIGH  = 1;
    localparam int W_WR_LOW   = 2;
    localparam int W_DONE     = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              vblank = 1'b0;
    logic              irqN = 1'b1;
    logic [ROM_AW-1:0] romAddr;
    logic [15:0]       romData;
    logic              busCsN, busRdN, busWrN, busDOe, busy, done;
    logic [4:0]        busA;
    logic [7:0]        busD;

    logic [15:0]       rom [0:ROM_DEPTH-1];
    logic [12:0]       expQ [$];
    logic [12:0]       expEntry;
    int                checks = 0;
    int                failures = 0;
    int                csLow = 0;
    int                wrLow = 0;
    logic              prevWr = 1'b1;
    int                n;

    always #5 clk = ~clk;

    always @(posedge clk) romData <= rom[romAddr];

    vera_init_sequencer #(
        .ROM_AW    (ROM_AW),
        .SETUP_CYC (2),
        .STROBE_CYC(4),
        .HOLD_CYC  (2),
        .DELAY_UNIT(256),
        .AUTO_START(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .rom_addr_o (romAddr),
        .rom_data_i (romData),
        .vblank_i   (vblank),
        .irq_n_i    (irqN),
        .bus_cs_n_o (busCsN),
        .bus_rd_n_o (busRdN),
        .bus_wr_n_o (busWrN),
        .bus_a_o    (busA),
        .bus_d_out_o(busD),
        .bus_d_oe_o (busDOe),
        .busy_o     (busy),
        .done_o     (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic restartFromReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] w0, input logic [15:0] w1,
                                 input logic [15:0] w2, input logic [15:0] w3,
                                 input logic [15:0] w4);
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 16'hE000;
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
        rom[4] = w4;
        restartFromReset();
    endtask

    task automatic waitUntil(input int kind, input int maxc, output int cnt);
        logic hit;
        cnt = 0;
        hit = 1'b0;
        while (!hit && cnt < maxc) begin
            @(negedge clk);
            cnt++;
            case (kind)
                W_CS_LOW:  hit = !busCsN;
                W_CS_HIGH: hit = busCsN;
                W_WR_LOW:  hit = !busWrN;
                default:   hit = done;
            endcase
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_kind_%0d: got timeout after %0d cycles, expected event", kind, cnt);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: a completed write is a wr_n rise outside reset.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                csLow  = 0;
                wrLow  = 0;
                prevWr = 1'b1;
            end else begin
                if (!busCsN) csLow++;
                if (!busWrN) wrLow++;
                if (!prevWr && busWrN) begin
                    checkOutput("write_expected", expQ.size() > 0, 1);
                    if (expQ.size() > 0) begin
                        expEntry = expQ.pop_front();
                        checkOutput("bus_a", busA, expEntry[12:8]);
                        checkOutput("bus_d", busD, expEntry[7:0]);
                        checkOutput("cs_low_cycles", csLow, 6);
                        checkOutput("wr_low_cycles", wrLow, 4);
                        checkOutput("d_oe_in_hold", busDOe, 1);
                        checkOutput("rd_n_high", busRdN, 1);
                    end
                    csLow = 0;
                    wrLow = 0;
                end
                prevWr = busWrN;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 16'hE000;
        repeat (2) @(negedge clk);
        checkOutput("reset_cs_n", busCsN, 1);
        checkOutput("reset_wr_n", busWrN, 1);
        checkOutput("reset_rd_n", busRdN, 1);
        checkOutput("reset_a", busA, 0);
        checkOutput("reset_d", busD, 0);
        checkOutput("reset_d_oe", busDOe, 0);
        checkOutput("reset_rom_addr", romAddr, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);

        // Single write then END, followed by a start-triggered rerun.
        expQ.push_back({5'h05, 8'h80});
        applyStimulus(16'h0580, 16'hE000, 16'hE000, 16'hE000, 16'hE000);
        waitUntil(W_DONE, 200, n);
        checkOutput("t1_done", done, 1);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_cs_idle", busCsN, 1);
        checkOutput("t1_oe_idle", busDOe, 0);
        checkOutput("t1_queue_empty", expQ.size(), 0);
        expQ.push_back({5'h05, 8'h80});
        pulseStart();
        checkOutput("t1_done_cleared", done, 0);
        checkOutput("t1_busy_on_start", busy, 1);
        waitUntil(W_CS_LOW, 20, n);
        checkOutput("t1_start_to_cs_low", n + 1, 3);
        waitUntil(W_DONE, 200, n);
        checkOutput("t1_rerun_queue_empty", expQ.size(), 0);

        // DELAY 3 then write, DELAY 0 then write.
        expQ.push_back({5'h01, 8'h11});
        expQ.push_back({5'h02, 8'h22});
        applyStimulus(16'h2003, 16'h0111, 16'h2000, 16'h0222, 16'hE000);
        waitUntil(W_CS_LOW, 2000, n);
        checkOutput("t2_delay3_to_cs_low", n, 773);
        waitUntil(W_CS_HIGH, 20, n);
        waitUntil(W_CS_LOW, 20, n);
        checkOutput("t2_delay0_gap", n, 6);
        waitUntil(W_DONE, 200, n);
        checkOutput("t2_queue_empty", expQ.size(), 0);

        // WAIT_VBLANK entered with vblank already high.
        vblank = 1'b1;
        expQ.push_back({5'h03, 8'h33});
        applyStimulus(16'h4000, 16'h0333, 16'hE000, 16'hE000, 16'hE000);
        repeat (20) @(negedge clk);
        checkOutput("t3_no_write_while_high", busCsN, 1);
        checkOutput("t3_busy_waiting", busy, 1);
        vblank = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("t3_no_write_while_low", busCsN, 1);
        vblank = 1'b1;
        waitUntil(W_CS_LOW, 10, n);
        checkOutput("t3_vblank_rise_to_cs_low", n, 3);
        waitUntil(W_DONE, 200, n);
        checkOutput("t3_queue_empty", expQ.size(), 0);
        vblank = 1'b0;

        // Reset during STROBE aborts the cycle; the rerun writes everything.
        applyStimulus(16'h0222, 16'h0333, 16'hE000, 16'hE000, 16'hE000);
        waitUntil(W_WR_LOW, 50, n);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t4_abort_cs_n", busCsN, 1);
        checkOutput("t4_abort_wr_n", busWrN, 1);
        checkOutput("t4_abort_d_oe", busDOe, 0);
        checkOutput("t4_abort_busy", busy, 0);
        expQ.push_back({5'h02, 8'h22});
        expQ.push_back({5'h03, 8'h33});
        reset = 1'b0;
        waitUntil(W_DONE, 300, n);
        checkOutput("t4_done", done, 1);
        checkOutput("t4_queue_empty", expQ.size(), 0);

        // ROM full of writes, no END: stop at the last address without wrap.
        for (int i = 0; i < ROM_DEPTH; i++) begin
            rom[i] = {3'b000, 5'(i + 8), 8'(8'hA0 + i)};
            expQ.push_back({5'(i + 8), 8'(8'hA0 + i)});
        end
        restartFromReset();
        waitUntil(W_CS_LOW, 20, n);
        pulseStart();
        waitUntil(W_DONE, 500, n);
        checkOutput("t5_queue_empty", expQ.size(), 0);
        checkOutput("t5_rom_addr_last", romAddr, ROM_DEPTH - 1);
        checkOutput("t5_busy_clear", busy, 0);
        for (int i = 0; i < ROM_DEPTH; i++) expQ.push_back({5'(i + 8), 8'(8'hA0 + i)});
        pulseStart();
        checkOutput("t5_done_cleared", done, 0);
        waitUntil(W_DONE, 500, n);
        checkOutput("t5_rerun_done", done, 1);
        checkOutput("t5_rerun_queue_empty", expQ.size(), 0);

        // Op 3 with irq_n high, then a NOP (op 5), then a write.
        irqN = 1'b1;
        expQ.push_back({5'h04, 8'h44});
        applyStimulus(16'h6000, 16'hA000, 16'h0444, 16'hE000, 16'hE000);
`ifdef VERA_SEQ_IRQ_WAIT_EN
        repeat (30) @(negedge clk);
        checkOutput("t6_irq_blocks", busCsN, 1);
        checkOutput("t6_busy_waiting", busy, 1);
        irqN = 1'b0;
        waitUntil(W_CS_LOW, 20, n);
        checkOutput("t6_irq_low_to_cs_low", n, 5);
`else
        waitUntil(W_CS_LOW, 20, n);
        checkOutput("t6_nop_to_cs_low", n, 7);
`endif
        waitUntil(W_DONE, 200, n);
        checkOutput("t6_queue_empty", expQ.size(), 0);
        irqN = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
